// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, timing record and sync-decoder state encoding.
// Used by both the VGA generator and the sync decoder.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   LOCK_FRAMES = 2;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int               CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = 11'd2047;

    typedef struct packed {
        logic [CNT_W-1:0] h_visible;
        logic [CNT_W-1:0] h_front;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_back;
        logic [CNT_W-1:0] v_visible;
        logic [CNT_W-1:0] v_front;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_visible: CNT_W'(H_VISIBLE),
        h_front:   CNT_W'(H_FRONT),
        h_sync:    CNT_W'(H_SYNC),
        h_back:    CNT_W'(H_BACK),
        v_visible: CNT_W'(V_VISIBLE),
        v_front:   CNT_W'(V_FRONT),
        v_sync:    CNT_W'(V_SYNC),
        v_back:    CNT_W'(V_BACK)
    };

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 11'd1;
    endfunction

    function automatic logic [CNT_W-1:0] h_total(input vga_timing_t t);
        return t.h_visible + t.h_front + t.h_sync + t.h_back;
    endfunction

    function automatic logic [CNT_W-1:0] v_total(input vga_timing_t t);
        return t.v_visible + t.v_front + t.v_sync + t.v_back;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input, normalises it to active-high and flags its leading edge.
// History resets to deasserted so a sync already asserted out of reset counts as an edge.
module sync_edge_detect #(
    parameter logic ACTIVE_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sync_i,
    output logic edge_o
);

    logic sync_r;
    logic prev_r;

    // Input register plus one cycle of history on the normalised level
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= (sync_i == ACTIVE_LEVEL);
            prev_r <= sync_r;
        end
    end

    assign edge_o = sync_r & ~prev_r;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers x/y/de from hsync/vsync, validates line and
// frame periods, and reports lock, frame start and period errors.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter vga_timing_t TIMING     = VGA_640X480,
    parameter logic        SYNC_LEVEL = SYNC_ACTIVE,
    parameter int          LOCK_COUNT = LOCK_FRAMES
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [3:0] red_i,
    input  logic [3:0] green_i,
    input  logic [3:0] blue_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       de_o,
    output logic [3:0] red_o,
    output logic [3:0] green_o,
    output logic [3:0] blue_o,
    output logic       frame_o,
    output logic       locked_o,
    output logic       err_o,
    output logic [7:0] err_count_o
);

    localparam logic [CNT_W-1:0] H_LAST      = h_total(TIMING) - 11'd1;
    localparam logic [CNT_W-1:0] V_LAST      = v_total(TIMING) - 11'd1;
    localparam logic [CNT_W-1:0] H_ACT_START = TIMING.h_sync + TIMING.h_back;
    localparam logic [CNT_W-1:0] H_ACT_END   = H_ACT_START + TIMING.h_visible;
    localparam logic [CNT_W-1:0] V_ACT_START = TIMING.v_sync + TIMING.v_back;
    localparam logic [CNT_W-1:0] V_ACT_END   = V_ACT_START + TIMING.v_visible;
    localparam int               GOOD_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);

    logic             h_edge_s;
    logic             v_edge_s;
    logic [11:0]      rgb_r;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             line_bad_s;
    logic             frame_bad_s;
    logic             check_fail_s;
    logic             lock_next_s;
    logic             de_next_s;
    sync_state_e      state_r;
    logic [GOOD_W-1:0] good_r;

    sync_edge_detect #(.ACTIVE_LEVEL(SYNC_LEVEL)) u_hsync_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sync_i  (hsync_i),
        .edge_o  (h_edge_s)
    );

    sync_edge_detect #(.ACTIVE_LEVEL(SYNC_LEVEL)) u_vsync_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sync_i  (vsync_i),
        .edge_o  (v_edge_s)
    );

    // Colour register, kept in step with the sync input registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rgb_r <= 12'd0;
        end else begin
            rgb_r <= {red_i, green_i, blue_i};
        end
    end

    // Next counter values; a vsync edge restarts the frame even when hsync fires too
    always_comb begin
        if (h_edge_s) begin
            h_next_s = {CNT_W{1'b0}};
        end else begin
            h_next_s = sat_inc(h_cnt_r);
        end
        if (v_edge_s) begin
            v_next_s = {CNT_W{1'b0}};
        end else if (h_edge_s) begin
            v_next_s = sat_inc(v_cnt_r);
        end else begin
            v_next_s = v_cnt_r;
        end
    end

    // Period checks use the pre-edge counts; lock_next_s is the lock status after this cycle
    always_comb begin
        line_bad_s   = h_edge_s && (h_cnt_r != H_LAST);
        frame_bad_s  = v_edge_s && (v_cnt_r != V_LAST);
        check_fail_s = (state_r != ST_SEARCH) && (line_bad_s || frame_bad_s);
        case (state_r)
            ST_LOCKED: lock_next_s = !check_fail_s;
            ST_TRACK:  lock_next_s = !check_fail_s && v_edge_s && (good_r == GOOD_LAST);
            default:   lock_next_s = 1'b0;
        endcase
        de_next_s = lock_next_s
                 && (h_next_s >= H_ACT_START) && (h_next_s < H_ACT_END)
                 && (v_next_s >= V_ACT_START) && (v_next_s < V_ACT_END);
    end

    // Line and frame position counters
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_cnt_r <= {CNT_W{1'b0}};
            v_cnt_r <= {CNT_W{1'b0}};
        end else begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
        end
    end

    // Lock FSM with its status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= ST_SEARCH;
            good_r      <= {GOOD_W{1'b0}};
            locked_o    <= 1'b0;
            frame_o     <= 1'b0;
            err_o       <= 1'b0;
            err_count_o <= 8'd0;
        end else begin
            locked_o <= lock_next_s;
            err_o    <= check_fail_s;
            frame_o  <= (state_r == ST_LOCKED) && v_edge_s && lock_next_s;
            if (check_fail_s && (err_count_o != 8'hFF)) begin
                err_count_o <= err_count_o + 8'd1;
            end
            case (state_r)
                ST_SEARCH: begin
                    if (v_edge_s) begin
                        state_r <= ST_TRACK;
                        good_r  <= {GOOD_W{1'b0}};
                    end
                end
                ST_TRACK: begin
                    if (check_fail_s) begin
                        state_r <= ST_SEARCH;
                    end else if (v_edge_s) begin
                        good_r <= good_r + GOOD_W'(1);
                        if (lock_next_s) begin
                            state_r <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (check_fail_s) begin
                        state_r <= ST_SEARCH;
                    end
                end
                default: state_r <= ST_SEARCH;
            endcase
        end
    end

    // Video outputs; everything but de is forced to zero outside active video
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            de_o    <= 1'b0;
            x_o     <= 10'd0;
            y_o     <= 10'd0;
            red_o   <= 4'd0;
            green_o <= 4'd0;
            blue_o  <= 4'd0;
        end else begin
            de_o    <= de_next_s;
            x_o     <= de_next_s ? 10'(h_next_s - H_ACT_START) : 10'd0;
            y_o     <= de_next_s ? 10'(v_next_s - V_ACT_START) : 10'd0;
            red_o   <= de_next_s ? rgb_r[11:8] : 4'd0;
            green_o <= de_next_s ? rgb_r[7:4]  : 4'd0;
            blue_o  <= de_next_s ? rgb_r[3:0]  : 4'd0;
        end
    end

endmodule
